parking_slot_manager: RTL and testbench
=======================================

// Module: parking_slot_manager
// PURPOSE
//   Registered, parametrised occupancy manager for an N-slot car park.
//   Keeps a free-slot bitmap. On an entry request it allocates the highest-index
//   free slot and reports that slot's number. On an exit request it frees the
//   named slot.
//   Keeps a live free-slot count and full/empty flags. Sits between the gate
//   sensors/controller and the display/billing logic, as the successor of the
//   combinational capacity-update path.
// PARAMETERS
//   NUM_SLOTS  8                         number of parking slots (>=2)
//   SLOT_W     $clog2(NUM_SLOTS)         width of a slot index
//   CNT_W      $clog2(NUM_SLOTS+1)       width of the free-slot counter
// PORTS
//   clk         in   1          single system clock, rising edge
//   rst_n       in   1          asynchronous, active-low reset
//   entry_req   in   1          car at entry gate; sampled every cycle it is high
//   exit_req    in   1          car leaving; sampled every cycle it is high
//   exit_slot   in   SLOT_W     slot being vacated; valid with exit_req
//   entry_grant out  1          1-cycle pulse: a slot was allocated
//   entry_slot  out  SLOT_W     allocated slot index; valid while entry_grant=1
//   entry_rej   out  1          1-cycle pulse: entry refused, park full
//   exit_ack    out  1          1-cycle pulse: exit_slot freed
//   exit_err    out  1          1-cycle pulse: exit_slot already free or >= NUM_SLOTS
//   free_map    out  NUM_SLOTS  bit i=1 means slot i is free
//   free_count  out  CNT_W      number of set bits in free_map
//   full        out  1          free_count==0
//   empty       out  1          free_count==NUM_SLOTS
// BEHAVIOUR
//   - Reset (async assert, sync release): free_map=all ones; free_count=NUM_SLOTS;
//     empty=1; full=0; entry_grant, entry_rej, exit_ack, exit_err = 0;
//     entry_slot = 0.
//   - All outputs are registered. A request sampled on edge k produces its response
//     pulse and its bitmap/count update together, visible after edge k.
//   - Latency is 1 cycle. There is no backpressure. A request held high for
//     M cycles is M separate requests.
//   - Entry: the allocator selects the highest index i with free_map[i]=1, from
//     the pre-edge bitmap. It clears bit i, decrements free_count, pulses
//     entry_grant and sets entry_slot=i.
//     If no slot is free: pulse entry_rej; bitmap and count unchanged;
//     entry_slot holds its last value.
//   - Exit: if exit_slot < NUM_SLOTS and free_map[exit_slot]=0, set the bit,
//     increment free_count and pulse exit_ack. Otherwise pulse exit_err with no
//     state change.
//   - Simultaneous entry and exit in one cycle:
//     - Both requests are evaluated against the pre-edge bitmap.
//     - The allocated slot can never equal a valid exit_slot, so both updates
//       apply.
//     - Net count change: 0 if both succeed, -1 or +1 if only one does.
//     - Full plus a valid exit: entry is rejected (the freed slot is not
//       reusable in the same cycle) and the exit is acked.
//     - Empty plus entry and an erroneous exit: grant the entry and pulse
//       exit_err.
//   - Counter arithmetic is CNT_W-bit and saturation-free. Wrap is impossible by
//     construction.
//     Invariant: free_count == popcount(free_map). full and empty are decoded from
//     the next-state count and registered, never lagging the count.
//   - rst_n asserted mid-operation: every slot becomes free immediately and any
//     in-flight pulse is dropped.
// STRUCTURE
//   - parking_pkg: NUM_SLOTS_DEF, the SLOT_W/CNT_W computation function and a
//     slot_idx_t typedef shared with the gate controller and display blocks.
//   - Sub-module slot_priority_enc (combinational, parametrised):
//     in = free_map; out = highest set index plus an any_free flag.
//     The top level holds only the registers, exit decode and counter.
// TESTING
//   1. Reset: assert rst_n=0 mid-sim -> free_map=8'hFF, free_count=8, empty=1,
//      full=0, all pulses 0.
//   2. Fill: entry_req high for 8 cycles from reset -> entry_slot=7,6,...,0 with
//      8 grants; free_map=8'h00, full=1. Cycle 9 -> entry_rej=1, no grant.
//   3. Exit error: free_map=8'hFF, exit_req with exit_slot=3 -> exit_err=1,
//      map unchanged. (For a NUM_SLOTS=6 build, exit_slot=7 -> exit_err.)
//   4. Simultaneous at full: free_map=8'h00, entry_req + exit_req(slot 5) ->
//      exit_ack=1, entry_rej=1, free_map=8'h20, count=1. Next cycle, entry only
//      -> grant slot 5.
//   5. Simultaneous mid-fill: free_map=8'h0F, entry + exit(slot 6) -> grant
//      slot 3, exit_ack, free_map=8'h47, count unchanged at 4.
//   6. Random request stream against a scoreboard model -> invariant
//      count==popcount(map) every cycle; full/empty consistent.

Source files
------------

// File: rtl/parking_pkg.sv
// ============================================================================
// Module   : parking_pkg
// Brief    : Shared sizing constants, width helper and slot index type for the
//            car-park occupancy blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package parking_pkg;

    localparam int NUM_SLOTS_DEF = 8;

    // Never returns zero, so a 1-slot index still has a usable width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SLOT_W_DEF = idx_width(NUM_SLOTS_DEF);
    localparam int CNT_W_DEF  = idx_width(NUM_SLOTS_DEF + 1);

    typedef logic [SLOT_W_DEF-1:0] slot_idx_t;

endpackage

`default_nettype wire

// File: rtl/slot_priority_enc.sv
// ============================================================================
// Module   : slot_priority_enc
// Brief    : Combinational encoder returning the highest set index of a map.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slot_priority_enc #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] map_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    // Ascending scan: the last hit wins, giving the highest set index.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (map_i[i]) begin
                idx_o = W'(i);
            end
        end
    end

    assign any_o = |map_i;

endmodule

`default_nettype wire

// File: rtl/parking_slot_manager.sv
// ============================================================================
// Module   : parking_slot_manager
// Brief    : Registered free-slot bitmap with highest-index allocation,
//            exit validation, live free count and full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_slot_manager
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int SLOT_W    = idx_width(NUM_SLOTS),
    parameter int CNT_W     = idx_width(NUM_SLOTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 entry_req,
    input  logic                 exit_req,
    input  logic [SLOT_W-1:0]    exit_slot,
    output logic                 entry_grant,
    output logic [SLOT_W-1:0]    entry_slot,
    output logic                 entry_rej,
    output logic                 exit_ack,
    output logic                 exit_err,
    output logic [NUM_SLOTS-1:0] free_map,
    output logic [CNT_W-1:0]     free_count,
    output logic                 full,
    output logic                 empty
);

    localparam logic [CNT_W-1:0] C_ALL_FREE = CNT_W'(NUM_SLOTS);

    logic [NUM_SLOTS-1:0] free_map_q,   free_map_d;
    logic [CNT_W-1:0]     free_count_q, free_count_d;
    logic [SLOT_W-1:0]    entry_slot_q, entry_slot_d;
    logic                 full_q, empty_q;
    logic                 entry_grant_q, entry_rej_q, exit_ack_q, exit_err_q;

    logic [SLOT_W-1:0]    enc_idx;
    logic                 enc_any;
    logic                 exit_in_range;
    logic                 grant_d, rej_d, ack_d, err_d;

    slot_priority_enc #(
        .N (NUM_SLOTS),
        .W (SLOT_W)
    ) u_enc (
        .map_i (free_map_q),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    assign exit_in_range = (32'(exit_slot) < NUM_SLOTS);

    // Both requests see the pre-edge map, so a freed slot is never re-granted
    // in the same cycle and the grant can never collide with a valid exit.
    always_comb begin
        grant_d = entry_req &&  enc_any;
        rej_d   = entry_req && !enc_any;
        ack_d   = 1'b0;
        if (exit_req && exit_in_range) begin
            ack_d = !free_map_q[exit_slot];
        end
        err_d   = exit_req && !ack_d;

        free_map_d = free_map_q;
        if (grant_d) begin
            free_map_d[enc_idx] = 1'b0;
        end
        if (ack_d) begin
            free_map_d[exit_slot] = 1'b1;
        end

        free_count_d = free_count_q - CNT_W'(grant_d) + CNT_W'(ack_d);
        entry_slot_d = grant_d ? enc_idx : entry_slot_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_map_q    <= '1;
            free_count_q  <= C_ALL_FREE;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            entry_slot_q  <= '0;
            entry_grant_q <= 1'b0;
            entry_rej_q   <= 1'b0;
            exit_ack_q    <= 1'b0;
            exit_err_q    <= 1'b0;
        end else begin
            free_map_q    <= free_map_d;
            free_count_q  <= free_count_d;
            full_q        <= (free_count_d == '0);
            empty_q       <= (free_count_d == C_ALL_FREE);
            entry_slot_q  <= entry_slot_d;
            entry_grant_q <= grant_d;
            entry_rej_q   <= rej_d;
            exit_ack_q    <= ack_d;
            exit_err_q    <= err_d;
        end
    end

    assign free_map    = free_map_q;
    assign free_count  = free_count_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign entry_slot  = entry_slot_q;
    assign entry_grant = entry_grant_q;
    assign entry_rej   = entry_rej_q;
    assign exit_ack    = exit_ack_q;
    assign exit_err    = exit_err_q;

endmodule

`default_nettype wire

// File: tb/tb_parking_slot_manager.sv
// ============================================================================
// Module   : tb_parking_slot_manager
// Brief    : Scoreboard bench for parking_slot_manager (8 slots).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_slot_manager;

    localparam int N = 8;

    logic       clk;
    logic       rst_n;
    logic       entry_req;
    logic       exit_req;
    logic [2:0] exit_slot;
    logic       entry_grant;
    logic [2:0] entry_slot;
    logic       entry_rej;
    logic       exit_ack;
    logic       exit_err;
    logic [7:0] free_map;
    logic [3:0] free_count;
    logic       full;
    logic       empty;

    parking_slot_manager #(.NUM_SLOTS(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .entry_req   (entry_req),
        .exit_req    (exit_req),
        .exit_slot   (exit_slot),
        .entry_grant (entry_grant),
        .entry_slot  (entry_slot),
        .entry_rej   (entry_rej),
        .exit_ack    (exit_ack),
        .exit_err    (exit_err),
        .free_map    (free_map),
        .free_count  (free_count),
        .full        (full),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       grant;
        logic [2:0] slot;
        logic       rej;
        logic       ack;
        logic       err;
        logic [7:0] map;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model: a plain array of "slot is free" flags.
    bit m_free[N];
    int m_last_slot;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_free[i] ? 1 : 0;
        return c;
    endfunction

    function automatic logic [7:0] m_map();
        logic [7:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_free[i];
        return v;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < N; i++) m_free[i] = 1'b1;
        m_last_slot = 0;
    endfunction

    // One request cycle: drive inputs, advance the model, queue the expectation.
    task automatic issue(input logic en, input logic ex, input int slot);
        exp_t e;
        int   pick;
        bit   exit_ok;
        @(negedge clk);
        entry_req = en;
        exit_req  = ex;
        exit_slot = 3'(slot);
        pick = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick < 0 && m_free[i]) pick = i;
        end
        exit_ok = ex && (slot < N) && !m_free[slot];
        e.grant = en && (pick >= 0);
        e.rej   = en && (pick < 0);
        e.ack   = exit_ok;
        e.err   = ex && !exit_ok;
        if (e.grant) begin
            m_free[pick] = 1'b0;
            m_last_slot  = pick;
        end
        if (exit_ok) m_free[slot] = 1'b1;
        e.slot  = 3'(m_last_slot);
        e.map   = m_map();
        e.cnt   = 4'(m_count());
        e.full  = (m_count() == 0);
        e.empty = (m_count() == N);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_map",   int'(free_map),   8'hFF);
        chk("rst_count", int'(free_count), N);
        chk("rst_empty", int'(empty),      1);
        chk("rst_full",  int'(full),       0);
        chk("rst_pulses", int'({entry_grant, entry_rej, exit_ack, exit_err}), 0);
        chk("rst_slot",  int'(entry_slot), 0);
        exp_q.delete();
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every response cycle is checked against the queued expectation.
    initial begin
        exp_t e;
        int   pc;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant", int'(entry_grant), int'(e.grant));
                if (e.grant) chk("slot", int'(entry_slot), int'(e.slot));
                else         chk("slot_hold", int'(entry_slot), int'(e.slot));
                chk("rej",   int'(entry_rej),  int'(e.rej));
                chk("ack",   int'(exit_ack),   int'(e.ack));
                chk("err",   int'(exit_err),   int'(e.err));
                chk("map",   int'(free_map),   int'(e.map));
                chk("count", int'(free_count), int'(e.cnt));
                chk("full",  int'(full),       int'(e.full));
                chk("empty", int'(empty),      int'(e.empty));
                pc = 0;
                for (int i = 0; i < N; i++) pc += free_map[i] ? 1 : 0;
                chk("inv_popcount", int'(free_count), pc);
            end
        end
    end

    initial begin
        int wait_cyc;
        rst_n     = 1'b0;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        exit_slot = '0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fill from reset, then one rejected entry at full.
        for (int i = 0; i < N + 1; i++) issue(1'b1, 1'b0, 0);
        // Full plus valid exit: reject + ack, then the freed slot is granted.
        issue(1'b1, 1'b1, 5);
        issue(1'b1, 1'b0, 0);
        // Free slots 0..3 to reach map 0x0F, then simultaneous entry and exit.
        for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, i);
        issue(1'b1, 1'b1, 6);
        issue(1'b0, 1'b0, 0);

        // Mid-run reset, then an exit on an already-free slot.
        do_reset();
        issue(1'b0, 1'b1, 3);
        // Empty plus entry and an erroneous exit.
        issue(1'b1, 1'b1, 2);

        for (int k = 0; k < 600; k++) begin
            issue(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
                  int'($urandom_range(0, N - 1)));
        end

        do_reset();
        issue(1'b1, 1'b0, 0);
        @(negedge clk);
        entry_req = 1'b0;
        exit_req  = 1'b0;

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("drain_timeout", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
